fetch_unit: RTL

Front-end fetch stage and producer side of the instruction buffer. Holds the PC, requests aligned `FETCH_WIDTH`-instruction lines from the I-cache and latches each returned line. It then pushes decoded-order `FETCH_PACKET`s into the instruction buffer, never exceeding the slot count the buffer advertises. A branch-mispredict redirect, asserted in the same cycle the instruction buffer is flushed, squashes any in-flight or held fetch and restarts fetch at the new PC.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_aligner.sv | 31 +++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch types: the packet pushed into the instruction buffer and the default fetch width.
// Also holds a small helper used to clamp push counts.
package fetch_unit_pkg;

  localparam int FETCH_WIDTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] inst;
    logic [31:0] NPC;
    logic        valid;
  } FETCH_PACKET;

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Combinational: turns a held I-cache line plus the PC's word offset into an oldest-first packet array.
// Zero latency, no state; the caller masks entries beyond its push count.
module fetch_aligner
  import fetch_unit_pkg::*;
#(
  parameter int  FETCH_WIDTH = FETCH_WIDTH_DEFAULT,
  localparam int OW          = $clog2(FETCH_WIDTH),
  localparam int CW          = $clog2(FETCH_WIDTH + 1)
) (
  input  logic [FETCH_WIDTH-1:0][31:0] line_i,
  input  logic [31:0]                  base_pc_i,
  input  logic [OW-1:0]                offset_i,
  output FETCH_PACKET [FETCH_WIDTH-1:0] pkt_o,
  output logic [CW-1:0]                remaining_o
);

  assign remaining_o = CW'(FETCH_WIDTH) - CW'(offset_i);

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pkt_o[i] = '0;
      if (i < int'(remaining_o)) begin
        pkt_o[i].PC    = base_pc_i + 32'(4 * i);
        pkt_o[i].inst  = line_i[OW'(i + int'(offset_i))];
        pkt_o[i].NPC   = base_pc_i + 32'(4 * i + 4);
        pkt_o[i].valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, line requests to the I-cache, hold buffer, pushes into the IB; FETCH_PERF_EN adds counters.
// First push one cycle after the response; pushes capped by ib_available_slots, redirect squashes everything.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          FETCH_WIDTH = FETCH_WIDTH_DEFAULT,
  parameter logic [31:0] RESET_PC    = 32'h0,
  localparam int         OW          = $clog2(FETCH_WIDTH),
  localparam int         CW          = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic [CW-1:0]                 ib_available_slots,
  output logic [CW-1:0]                 num_pushes,
  output FETCH_PACKET [FETCH_WIDTH-1:0] new_ib_entry,
  output logic                          icache_req_valid,
  output logic [31:0]                   icache_req_addr,
  input  logic                          icache_req_ready,
  input  logic                          icache_rsp_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]  icache_rsp_data
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                   perf_fetched_count,
  output logic [31:0]                   perf_stall_cycles
`endif
);

  localparam int LB = OW + 2;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  pc_q, pc_d;
  logic                         stale_q, stale_d;
  logic [FETCH_WIDTH-1:0][31:0] hold_q, hold_d;

  FETCH_PACKET [FETCH_WIDTH-1:0] aligned;
  logic [CW-1:0]                 remaining;
  logic [CW-1:0]                 push_n;
  logic [31:0]                   redirect_pc_al;

  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

  fetch_aligner #(.FETCH_WIDTH(FETCH_WIDTH)) u_aligner (
    .line_i      (hold_q),
    .base_pc_i   (pc_q),
    .offset_i    (pc_q[LB-1:2]),
    .pkt_o       (aligned),
    .remaining_o (remaining)
  );

  always_comb begin
    push_n = '0;
    if (state_q == S_HOLD && !redirect_valid && !reset) begin
      push_n = CW'(umin(int'(remaining), int'(ib_available_slots)));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      stale_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    hold_d  = hold_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc_al;
        end else if (icache_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response can never be reclaimed once requested, so a redirect here only marks it stale.
        if (redirect_valid) begin
          pc_d = redirect_pc_al;
          if (icache_rsp_valid) begin
            stale_d = 1'b0;
            state_d = S_REQ;
          end else begin
            stale_d = 1'b1;
          end
        end else if (icache_rsp_valid) begin
          if (stale_q) begin
            stale_d = 1'b0;
            state_d = S_REQ;
          end else begin
            hold_d  = icache_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc_al;
          hold_d  = '0;
          state_d = S_REQ;
        end else begin
          pc_d = pc_q + (32'(push_n) << 2);
          if (push_n == remaining) begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    icache_req_valid = (state_q == S_REQ) && !redirect_valid && !reset;
    icache_req_addr  = {pc_q[31:LB], {LB{1'b0}}};
    num_pushes       = push_n;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      new_ib_entry[i] = (i < int'(push_n)) ? aligned[i] : '0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;
  logic [32:0] fetched_sum;
  logic        stall_cycle;

  assign stall_cycle = (state_q == S_WAIT) ||
                       (state_q == S_HOLD && ib_available_slots == '0);

  always_comb begin
    fetched_sum = {1'b0, fetched_q} + 33'(push_n);
    fetched_d   = fetched_sum[32] ? '1 : fetched_sum[31:0];
    stall_d     = stall_q;
    if (stall_cycle && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched_count = fetched_q;
  assign perf_stall_cycles  = stall_q;
`endif

endmodule
